// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and address-split widths for the data cache
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return 32 - off_w(line_words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - valid/dirty/tag/data storage for the direct-mapped data cache
// One combinational read port; one write port taking either a single word or a whole line.
module dcache_array
  import cache_pkg::*;
#(
  parameter int LINES      = 32,
  parameter int LINE_WORDS = 8,
  parameter int MEM_W      = 256,
  parameter int IDX        = idx_w(LINES),
  parameter int TAG_W      = tag_w(LINES, LINE_WORDS),
  parameter int WSEL_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX-1:0]    rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [MEM_W-1:0]  rd_line,
  input  logic [IDX-1:0]    wr_idx,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [MEM_W-1:0]  line_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [MEM_W-1:0] data_q [LINES];

  // Only the status bits are reset; tag and data are qualified by valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[wr_idx]  <= line_tag;
      data_q[wr_idx] <= line_data;
    end else if (word_we) begin
      data_q[wr_idx][word_sel*32 +: 32] <= word_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// Hit path is combinational; misses stall the pipeline through WRITEBACK/ALLOCATE.
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES      = 32,
  parameter int LINE_WORDS = 8,
  parameter int MEM_W      = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [MEM_W-1:0] mem_wdata_o,
  input  logic [MEM_W-1:0] mem_rdata_i,
  input  logic             mem_ack_i
);

  localparam int OFF    = off_w(LINE_WORDS);
  localparam int IDX    = idx_w(LINES);
  localparam int TAG_W  = tag_w(LINES, LINE_WORDS);
  localparam int WSEL_W = $clog2(LINE_WORDS);

  state_t state;

  logic [WSEL_W-1:0] word_sel;
  logic [IDX-1:0]    addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic              byte_unused;

  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [MEM_W-1:0]  rd_line;
  logic              hit;
  logic              word_we;
  logic              line_we;

  assign word_sel    = addr_i[OFF-1:2];
  assign addr_idx    = addr_i[OFF+IDX-1:OFF];
  assign addr_tag    = addr_i[31:OFF+IDX];
  assign byte_unused = ^addr_i[1:0];

  assign hit     = req_i & rd_valid & (rd_tag == addr_tag);
  assign word_we = (state == IDLE) & hit & we_i;
  assign line_we = (state == ALLOCATE) & mem_ack_i;

  dcache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .MEM_W      (MEM_W)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx    (addr_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_idx    (addr_idx),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (wdata_i),
    .line_we   (line_we),
    .line_tag  (addr_tag),
    .line_data (mem_rdata_i)
  );

  // Gated by rst_i so both drop the moment reset asserts, even with req_i held high.
  assign rdata_o = (rst_i && state == IDLE && hit && !we_i) ? rd_line[word_sel*32 +: 32] : 32'd0;
  assign stall_o = rst_i && ((state != IDLE) || (req_i && !hit));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && !hit) begin
            mem_req_o <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state       <= WRITEBACK;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {rd_tag, addr_idx, {OFF{1'b0}}};
              mem_wdata_o <= rd_line;
            end else begin
              state      <= ALLOCATE;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {addr_tag, addr_idx, {OFF{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= ALLOCATE;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= {addr_tag, addr_idx, {OFF{1'b0}}};
            mem_wdata_o <= '0;
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

  localparam int LINES      = 32;
  localparam int LINE_WORDS = 8;
  localparam int MEM_W      = 256;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_i;
  logic             we_i;
  logic [31:0]      addr_i;
  logic [31:0]      wdata_i;
  logic [31:0]      rdata_o;
  logic             stall_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [MEM_W-1:0] mem_wdata_o;
  logic [MEM_W-1:0] mem_rdata_i;
  logic             mem_ack_i;

  dcache_ctrl #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .MEM_W      (MEM_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    int          stalls;
    string       name;
  } cpu_exp_t;

  typedef struct {
    logic             we;
    logic [31:0]      addr;
    logic [MEM_W-1:0] wdata;
    string            name;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int n_checks  = 0;
  int n_pass    = 0;
  int stall_cnt = 0;
  int mem_lat   = 3;
  int mem_cnt   = 0;
  bit mem_model_en = 1'b1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Memory images: word k of line A = 0x12345678 + k*0x01010101, of line B = 0xA0000000 + k.
  function automatic logic [MEM_W-1:0] line_a();
    logic [MEM_W-1:0] l;
    for (int k = 0; k < LINE_WORDS; k++) l[k*32 +: 32] = 32'h1234_5678 + k * 32'h0101_0101;
    return l;
  endfunction

  function automatic logic [MEM_W-1:0] line_b();
    logic [MEM_W-1:0] l;
    for (int k = 0; k < LINE_WORDS; k++) l[k*32 +: 32] = 32'hA000_0000 + k;
    return l;
  endfunction

  // Memory model: ack in the mem_lat-th cycle that mem_req_o is high.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_model_en) begin
        mem_ack_i = 1'b0;
        if (mem_req_o) begin
          mem_cnt++;
          if (mem_cnt >= mem_lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = (mem_addr_o == 32'h40) ? line_a() : line_b();
            mem_cnt     = 0;
          end
        end else begin
          mem_cnt = 0;
        end
      end
    end
  end

  // CPU-side monitor: counts stall cycles, pops on each completed access.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) stall_cnt = 0;
      else if (req_i) begin
        if (stall_o) stall_cnt++;
        else if (cpu_q.size() == 0) begin
          n_checks++;
          $display("FAIL cpu_unexpected: access completed at addr %h with nothing expected", addr_i);
        end else begin
          e = cpu_q.pop_front();
          check({e.name, "_rdata"}, 256'(rdata_o), 256'(e.rdata));
          check({e.name, "_stalls"}, 256'(stall_cnt), 256'(e.stalls));
          stall_cnt = 0;
        end
      end
    end
  end

  // Memory-side monitor: pops on each acknowledged transaction.
  initial begin
    mem_exp_t m;
    forever begin
      @(negedge clk_i);
      if (rst_i && mem_req_o && mem_ack_i) begin
        if (mem_q.size() == 0) begin
          n_checks++;
          $display("FAIL mem_unexpected: transaction at %h we=%b with nothing expected", mem_addr_o, mem_we_o);
        end else begin
          m = mem_q.pop_front();
          check({m.name, "_we"}, 256'(mem_we_o), 256'(m.we));
          check({m.name, "_addr"}, 256'(mem_addr_o), 256'(m.addr));
          if (m.we) check({m.name, "_wdata"}, mem_wdata_o, m.wdata);
        end
      end
    end
  end

  task automatic push_cpu(input string name, input logic we, input logic [31:0] rdata, input int stalls);
    cpu_exp_t e;
    e.we = we; e.rdata = rdata; e.stalls = stalls; e.name = name;
    cpu_q.push_back(e);
  endtask

  task automatic push_mem(input string name, input logic we, input logic [31:0] addr, input logic [MEM_W-1:0] wdata);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.wdata = wdata; m.name = name;
    mem_q.push_back(m);
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    @(negedge clk_i);
    while (stall_o && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    if (stall_o) begin
      n_checks++;
      $display("FAIL %s_timeout: stall_o still 1 after %0d cycles, required 0", name, cyc);
    end
  endtask

  task automatic cpu_access(input string name, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_stalls);
    push_cpu(name, we, exp_rdata, exp_stalls);
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    wait_done(name);
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_stall"}, 256'(stall_o), 256'(0));
    check({name, "_mem_req"}, 256'(mem_req_o), 256'(0));
    check({name, "_mem_we"}, 256'(mem_we_o), 256'(0));
    check({name, "_mem_addr"}, 256'(mem_addr_o), 256'(0));
    check({name, "_mem_wdata"}, mem_wdata_o, 256'(0));
    check({name, "_rdata"}, 256'(rdata_o), 256'(0));
  endtask

  initial begin
    logic [MEM_W-1:0] wb_line;
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk_i);
    check_quiet("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    push_mem("cold_fill", 1'b0, 32'h40, '0);
    cpu_access("cold_load", 1'b0, 32'h40, 32'h0, 32'h1234_5678, 4);
    cpu_access("hit_w1", 1'b0, 32'h44, 32'h0, 32'h1335_5779, 0);
    cpu_access("store_hit", 1'b1, 32'h48, 32'hDEAD_BEEF, 32'h0, 0);
    cpu_access("load_stored", 1'b0, 32'h48, 32'h0, 32'hDEAD_BEEF, 0);

    wb_line = line_a();
    wb_line[95:64] = 32'hDEAD_BEEF;
    push_mem("victim_wb", 1'b1, 32'h40, wb_line);
    push_mem("conflict_fill", 1'b0, 32'h440, '0);
    cpu_access("conflict_load", 1'b0, 32'h440, 32'h0, 32'hA000_0000, 7);
    cpu_access("hit_w7", 1'b0, 32'h45C, 32'h0, 32'hA000_0007, 0);

    push_mem("store_fill", 1'b0, 32'h80, '0);
    cpu_access("store_miss", 1'b1, 32'h84, 32'hCAFE_F00D, 32'h0, 4);
    cpu_access("load_alloc_store", 1'b0, 32'h84, 32'h0, 32'hCAFE_F00D, 0);
    cpu_access("load_alloc_w0", 1'b0, 32'h80, 32'h0, 32'hA000_0000, 0);

    // Reset asserted while a fill is outstanding.
    mem_lat = 10;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
    repeat (3) @(negedge clk_i);
    check("pre_rst_mem_req", 256'(mem_req_o), 256'(1));
    check("pre_rst_mem_we", 256'(mem_we_o), 256'(0));
    check("pre_rst_mem_addr", 256'(mem_addr_o), 256'(32'h40));
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_mem_req_drop", 256'(mem_req_o), 256'(0));
    check("rst_stall_drop", 256'(stall_o), 256'(0));
    check("rst_rdata", 256'(rdata_o), 256'(0));
    mem_lat = 2;
    push_mem("refill", 1'b0, 32'h40, '0);
    push_cpu("reload_after_rst", 1'b0, 32'h1234_5678, 3);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    wait_done("reload_after_rst");
    @(posedge clk_i); #1;
    req_i = 1'b0;

    // Spurious ack while idle.
    @(posedge clk_i); #1;
    mem_model_en = 1'b0;
    mem_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check_quiet("spurious_ack");
    end
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    mem_model_en = 1'b1;
    cpu_access("hit_after_spurious", 1'b0, 32'h40, 32'h0, 32'h1234_5678, 0);

    repeat (3) @(negedge clk_i);
    check("cpu_queue_drained", 256'(cpu_q.size()), 256'(0));
    check("mem_queue_drained", 256'(mem_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
